// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, register-address width and perf-counter layout.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PERF_CNT_W = 32;

  // Slot order inside the perf-counter bank.
  localparam int PERF_STALL  = 0;
  localparam int PERF_FLUSH  = 1;
  localparam int PERF_FREEZE = 2;
  localparam int PERF_NUM    = 3;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  function automatic logic load_use_hit(
    input logic                  memread,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use_rs2
  );
    // x0 is hardwired to zero, so a load into it never creates a dependency.
    return memread && (rd != '0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard-detection inputs and pipeline-register control outputs.
// Perf-counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] ifid_rs1_i;
  logic [REG_ADDR_W-1:0] ifid_rs2_i;
  logic                  ifid_use_rs2_i;
  logic [REG_ADDR_W-1:0] idex_rd_i;
  logic                  idex_memread_i;
  logic                  branch_taken_i;
  logic                  dmem_req_i;
  logic                  dmem_ack_i;

  logic pc_we_o;
  logic ifid_we_o;
  logic idex_we_o;
  logic exmem_we_o;
  logic memwb_we_o;
  logic ifid_flush_o;
  logic idex_flush_o;
  logic stall_o;
  logic err_o;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_o;
  logic [PERF_CNT_W-1:0] flush_cnt_o;
  logic [PERF_CNT_W-1:0] freeze_cnt_o;
`endif

  modport master (
    output ifid_rs1_i, ifid_rs2_i, ifid_use_rs2_i, idex_rd_i, idex_memread_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cnt_o, flush_cnt_o, freeze_cnt_o,
`endif
    input  pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o,
           ifid_flush_o, idex_flush_o, stall_o, err_o
  );

  modport slave (
    input  ifid_rs1_i, ifid_rs2_i, ifid_use_rs2_i, idex_rd_i, idex_memread_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cnt_o, flush_cnt_o, freeze_cnt_o,
`endif
    output pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o,
           ifid_flush_o, idex_flush_o, stall_o, err_o
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// hazard_perf_cnt: bank of free-running wrap-around event counters,
// one per increment strobe; used only when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [PERF_NUM-1:0]                inc_i,
  output logic [PERF_NUM-1:0][PERF_CNT_W-1:0] cnt_o
);

  generate
    for (genvar gi = 0; gi < PERF_NUM; gi++) begin : g_cnt
      logic [PERF_CNT_W-1:0] r_cnt;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_cnt <= '0;
        end else if (inc_i[gi]) begin
          r_cnt <= r_cnt + PERF_CNT_W'(1);
        end
      end

      assign cnt_o[gi] = r_cnt;
    end
  endgenerate

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubble, branch flush, memory freeze
// with timeout flag. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_err;

  logic w_freeze;
  logic w_load_use;
  logic w_pc_we;
  logic w_ifid_we;
  logic w_idex_we;
  logic w_exmem_we;
  logic w_memwb_we;
  logic w_ifid_flush;
  logic w_idex_flush;

  assign w_freeze   = hz.dmem_req_i & ~hz.dmem_ack_i;
  assign w_load_use = load_use_hit(hz.idex_memread_i, hz.idex_rd_i,
                                   hz.ifid_rs1_i, hz.ifid_rs2_i, hz.ifid_use_rs2_i);

  // Pending branch/load-use inputs are simply held by the frozen pipeline
  // registers, so they resurface unchanged in the first unfrozen cycle.
  always_comb begin
    w_pc_we      = 1'b1;
    w_ifid_we    = 1'b1;
    w_idex_we    = 1'b1;
    w_exmem_we   = 1'b1;
    w_memwb_we   = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    if (rst_i || w_freeze) begin
      w_pc_we    = 1'b0;
      w_ifid_we  = 1'b0;
      w_idex_we  = 1'b0;
      w_exmem_we = 1'b0;
      w_memwb_we = 1'b0;
    end else if (hz.branch_taken_i) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_load_use) begin
      w_pc_we      = 1'b0;
      w_ifid_we    = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_wait_cnt <= '0;
          if (w_freeze) begin
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (!hz.dmem_ack_i && (r_wait_cnt != WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (r_wait_cnt == WAIT_LAST) begin
              r_err <= 1'b1;
            end
          end
          // A withdrawn request counts as completion just like an ack.
          if (hz.dmem_ack_i || !hz.dmem_req_i) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign hz.pc_we_o      = w_pc_we;
  assign hz.ifid_we_o    = w_ifid_we;
  assign hz.idex_we_o    = w_idex_we;
  assign hz.exmem_we_o   = w_exmem_we;
  assign hz.memwb_we_o   = w_memwb_we;
  assign hz.ifid_flush_o = w_ifid_flush;
  assign hz.idex_flush_o = w_idex_flush;
  assign hz.stall_o      = ~(w_pc_we & w_ifid_we & w_idex_we & w_exmem_we & w_memwb_we);
  assign hz.err_o        = r_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_NUM-1:0]                 w_perf_inc;
  logic [PERF_NUM-1:0][PERF_CNT_W-1:0] w_perf_cnt;

  assign w_perf_inc[PERF_STALL]  = ~w_freeze & ~hz.branch_taken_i & w_load_use;
  assign w_perf_inc[PERF_FLUSH]  = ~w_freeze & hz.branch_taken_i;
  assign w_perf_inc[PERF_FREEZE] = w_freeze;

  hazard_perf_cnt u_perf_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_perf_inc),
    .cnt_o (w_perf_cnt)
  );

  assign hz.stall_cnt_o  = w_perf_cnt[PERF_STALL];
  assign hz.flush_cnt_o  = w_perf_cnt[PERF_FLUSH];
  assign hz.freeze_cnt_o = w_perf_cnt[PERF_FREEZE];
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes expected outputs
// from a rule-level reference model, a monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz_if ();

  pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz_if)
  );

  typedef struct {
    int           id;
    logic [4:0]   we;      // {pc, ifid, idex, exmem, memwb}
    logic [1:0]   flush;   // {ifid, idex}
    logic         stall;
    logic         err;
    logic [31:0]  n_stall;
    logic [31:0]  n_flush;
    logic [31:0]  n_freeze;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;
  int   txn_id = 0;

  // Reference model state: "waiting" means the previous cycle was frozen.
  bit          m_waiting = 0;
  int          m_wait    = 0;
  bit          m_err     = 0;
  int unsigned m_stall   = 0;
  int unsigned m_flush   = 0;
  int unsigned m_freeze  = 0;

  function automatic bit model_load_use();
    int rd;
    rd = int'(hz_if.idex_rd_i);
    return hz_if.idex_memread_i && rd != 0 &&
           (rd == int'(hz_if.ifid_rs1_i) ||
            (hz_if.ifid_use_rs2_i && rd == int'(hz_if.ifid_rs2_i)));
  endfunction

  // Apply one clock edge of model evolution using the inputs held over it.
  task automatic model_edge();
    bit frz;
    if (rst) begin
      m_waiting = 0; m_wait = 0; m_err = 0;
      m_stall = 0; m_flush = 0; m_freeze = 0;
    end else begin
      frz = hz_if.dmem_req_i && !hz_if.dmem_ack_i;
      if (frz) m_freeze++;
      else if (hz_if.branch_taken_i) m_flush++;
      else if (model_load_use()) m_stall++;
      if (m_waiting) begin
        if (!hz_if.dmem_ack_i && m_wait < TIMEOUT) begin
          m_wait++;
          if (m_wait == TIMEOUT) m_err = 1;
        end
      end else begin
        m_wait = 0;
      end
      m_waiting = frz;
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.id = txn_id;
    e.we = 5'b11111;
    e.flush = 2'b00;
    if (rst || (hz_if.dmem_req_i && !hz_if.dmem_ack_i)) e.we = 5'b00000;
    else if (hz_if.branch_taken_i) e.flush = 2'b11;
    else if (model_load_use()) begin
      e.we = 5'b00111;
      e.flush = 2'b01;
    end
    e.stall    = (e.we != 5'b11111);
    e.err      = rst ? 1'b0 : m_err;
    e.n_stall  = rst ? 32'd0 : 32'(m_stall);
    e.n_flush  = rst ? 32'd0 : 32'(m_flush);
    e.n_freeze = rst ? 32'd0 : 32'(m_freeze);
    return e;
  endfunction

  task automatic step(input bit r, input int rs1, input int rs2, input bit u2,
                      input int rd, input bit mr, input bit br,
                      input bit req, input bit ack);
    @(posedge clk);
    model_edge();
    #1;
    rst                  = r;
    hz_if.ifid_rs1_i     = 5'(rs1);
    hz_if.ifid_rs2_i     = 5'(rs2);
    hz_if.ifid_use_rs2_i = u2;
    hz_if.idex_rd_i      = 5'(rd);
    hz_if.idex_memread_i = mr;
    hz_if.branch_taken_i = br;
    hz_if.dmem_req_i     = req;
    hz_if.dmem_ack_i     = ack;
    #1;
    exp_q.push_back(model_outputs());
    txn_id++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    logic [4:0] we_a;
    logic [1:0] fl_a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        we_a = {hz_if.pc_we_o, hz_if.ifid_we_o, hz_if.idex_we_o,
                hz_if.exmem_we_o, hz_if.memwb_we_o};
        fl_a = {hz_if.ifid_flush_o, hz_if.idex_flush_o};
        $display("[TB] txn %0d rst=%b we=%b flush=%b stall=%b err=%b",
                 e.id, rst, we_a, fl_a, hz_if.stall_o, hz_if.err_o);
        tests++;
        if (we_a !== e.we) begin
          errors++;
          $display("FAIL txn %0d write_enables got %b want %b", e.id, we_a, e.we);
        end
        tests++;
        if (fl_a !== e.flush) begin
          errors++;
          $display("FAIL txn %0d flushes got %b want %b", e.id, fl_a, e.flush);
        end
        tests++;
        if (hz_if.stall_o !== e.stall) begin
          errors++;
          $display("FAIL txn %0d stall got %b want %b", e.id, hz_if.stall_o, e.stall);
        end
        tests++;
        if (hz_if.err_o !== e.err) begin
          errors++;
          $display("FAIL txn %0d err got %b want %b", e.id, hz_if.err_o, e.err);
        end
`ifdef HAZARD_PERF_CNT_EN
        tests++;
        if (hz_if.stall_cnt_o !== e.n_stall) begin
          errors++;
          $display("FAIL txn %0d stall_cnt got %0d want %0d", e.id, hz_if.stall_cnt_o, e.n_stall);
        end
        tests++;
        if (hz_if.flush_cnt_o !== e.n_flush) begin
          errors++;
          $display("FAIL txn %0d flush_cnt got %0d want %0d", e.id, hz_if.flush_cnt_o, e.n_flush);
        end
        tests++;
        if (hz_if.freeze_cnt_o !== e.n_freeze) begin
          errors++;
          $display("FAIL txn %0d freeze_cnt got %0d want %0d", e.id, hz_if.freeze_cnt_o, e.n_freeze);
        end
`endif
      end
    end
  end

  initial begin
    int budget;
    hz_if.ifid_rs1_i = '0;
    hz_if.ifid_rs2_i = '0;
    hz_if.ifid_use_rs2_i = 1'b0;
    hz_if.idex_rd_i = '0;
    hz_if.idex_memread_i = 1'b0;
    hz_if.branch_taken_i = 1'b0;
    hz_if.dmem_req_i = 1'b0;
    hz_if.dmem_ack_i = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Load-use via rs1, then the bubble has advanced.
    step(0, 5, 0, 0, 5, 1, 0, 0, 0);
    step(0, 5, 0, 0, 5, 0, 0, 0, 0);
    // Load into x0 never stalls.
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    // rs2 gating.
    step(0, 1, 7, 0, 7, 1, 0, 0, 0);
    step(0, 1, 7, 1, 7, 1, 0, 0, 0);
    step(0, 1, 7, 1, 7, 0, 0, 0, 0);
    // Branch together with load-use.
    step(0, 5, 0, 0, 5, 1, 1, 0, 0);
    idle();

    // Memory wait: 3 frozen cycles, then ack; pending load-use held through it.
    for (int i = 0; i < 3; i++) step(0, 3, 0, 0, 3, 1, 0, 1, 0);
    step(0, 3, 0, 0, 3, 1, 0, 1, 1);
    idle();

    // Timeout with no ack; err must persist after the ack.
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    idle();

    // Reset in the middle of a wait.
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Counter scenario: 2 stalls, 1 flush, 3 frozen cycles after a reset.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 0, 2, 1, 0, 0, 0);
    idle();
    step(0, 1, 4, 1, 4, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();

    // Randomized traffic with small register numbers to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      bit r, req, ack;
      r   = ($urandom_range(0, 63) == 0);
      req = ($urandom_range(0, 2) == 0);
      ack = req && ($urandom_range(0, 3) == 0);
      step(r, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), req, ack);
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
